// File: rtl/rf_operand_fetch_if.sv
// ----------------------------------------------------------------------------
// rf_operand_fetch_if
//
// Purpose: bundles every bus-level signal of the operand-fetch block. This
// covers the decode-side request handshake, the writeback port, the 16x32
// register-file port pair (one write port, two synchronous read ports) and
// the execute-side operand handshake.
//
// Modports:
//   slave  - the operand-fetch block itself (rf_operand_fetch).
//   master - its environment: decode, writeback source, RF and execute.
//
// Signal summary (direction as seen by the slave):
//   req_valid/req_ready/req_rs0/req_rs1/req_tag  request in, valid/ready
//   wb_en/wb_index/wb_data                       writeback in
//   rf_wr_en/rf_wr_index/rf_wr_data              RF write port out
//   rf_rd0_index/rf_rd1_index                    RF read indices out
//   rf_rd0_data/rf_rd1_data                      RF read data in (registered)
//   out_valid/out_ready/out_op0/out_op1/out_tag  operands out, valid/ready
// ----------------------------------------------------------------------------
interface rf_operand_fetch_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_rs0;
  logic [3:0]       req_rs1;
  logic [TAG_W-1:0] req_tag;

  logic             wb_en;
  logic [3:0]       wb_index;
  logic [31:0]      wb_data;

  logic             rf_wr_en;
  logic [3:0]       rf_wr_index;
  logic [31:0]      rf_wr_data;
  logic [3:0]       rf_rd0_index;
  logic [3:0]       rf_rd1_index;
  logic [31:0]      rf_rd0_data;
  logic [31:0]      rf_rd1_data;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_op0;
  logic [31:0]      out_op1;
  logic [TAG_W-1:0] out_tag;

  modport slave (
    input  req_valid, req_rs0, req_rs1, req_tag,
    output req_ready,
    input  wb_en, wb_index, wb_data,
    output rf_wr_en, rf_wr_index, rf_wr_data,
    output rf_rd0_index, rf_rd1_index,
    input  rf_rd0_data, rf_rd1_data,
    output out_valid, out_op0, out_op1, out_tag,
    input  out_ready
  );

  modport master (
    output req_valid, req_rs0, req_rs1, req_tag,
    input  req_ready,
    output wb_en, wb_index, wb_data,
    input  rf_wr_en, rf_wr_index, rf_wr_data,
    input  rf_rd0_index, rf_rd1_index,
    output rf_rd0_data, rf_rd1_data,
    input  out_valid, out_op0, out_op1, out_tag,
    output out_ready
  );
endinterface

// File: rtl/rf_operand_fetch.sv
// ----------------------------------------------------------------------------
// rf_operand_fetch
//
// Purpose: the client side of a 16x32 register file that has two synchronous
// read ports and one write port. The block sits between decode and execute.
// It accepts operand-fetch requests (two source indices plus a tag), drives
// the RF read indices, and hides the RF's one-cycle read latency and its
// read-before-write behaviour by forwarding matching writebacks. Both
// operands are presented on a valid/ready output.
//
// Pipeline:
//   B - RF read in flight (bValid, bRs0/1, bTag)
//   O - output register   (out_valid, out_op0/1, out_tag)
//   Latency is two edges from acceptance to out_valid.
//   Throughput is one request per cycle while out_ready is held high.
//
// Ports:
//   clk      in   single clock, all state updates on posedge
//   reset_n  in   asynchronous active-low reset
//   bus      slave modport of rf_operand_fetch_if (request, writeback,
//                 RF ports and operand output)
//
// Configuration macro:
//   OPFETCH_HOLD_REFRESH_EN - when defined, a writeback that hits a held
//   operand's source index while the output is stalled overwrites that
//   operand. When undefined, held operands stay frozen at their capture value.
// ----------------------------------------------------------------------------
module rf_operand_fetch #(
  parameter int TAG_W = 4
) (
  input logic              clk,
  input logic              reset_n,
  rf_operand_fetch_if.slave bus
);

  // B stage
  logic             bValid;
  logic [3:0]       bRs0;
  logic [3:0]       bRs1;
  logic [TAG_W-1:0] bTag;

  // O stage
  logic             outValid;
  logic [31:0]      outOp0;
  logic [31:0]      outOp1;
  logic [TAG_W-1:0] outTag;

  // Bypass register: remembers a write that landed on the same edge as an
  // RF read, because the RF returns the pre-write value for that read.
  logic             bypHit0;
  logic             bypHit1;
  logic [31:0]      bypData;

  logic             bAdv;
  logic             reqReady;
  logic             reqFire;
  logic             oCapture;
  logic [3:0]       rdIdx0;
  logic [3:0]       rdIdx1;
  logic [31:0]      bOp0;
  logic [31:0]      bOp1;
  logic [31:0]      capOp0;
  logic [31:0]      capOp1;

  // --------------------------------------------------------------------------
  // Handshake and read-index steering
  // --------------------------------------------------------------------------
  assign bAdv     = !outValid || bus.out_ready;
  assign reqReady = !bValid || bAdv;
  assign reqFire  = bus.req_valid && reqReady;
  assign oCapture = bValid && bAdv;

  // A stalled B re-reads its own indices every edge. This keeps RF data
  // valid for B in the cycle after any edge, no matter how long it waits.
  assign rdIdx0 = reqFire ? bus.req_rs0 : bRs0;
  assign rdIdx1 = reqFire ? bus.req_rs1 : bRs1;

  assign bus.rf_rd0_index = rdIdx0;
  assign bus.rf_rd1_index = rdIdx1;
  assign bus.req_ready    = reqReady;

  // Writes go straight to the RF and are never stalled.
  assign bus.rf_wr_en    = bus.wb_en;
  assign bus.rf_wr_index = bus.wb_index;
  assign bus.rf_wr_data  = bus.wb_data;

  // --------------------------------------------------------------------------
  // Operand selection. Priority follows write age: a write on the capture
  // edge, then the bypass register, then RF data.
  // --------------------------------------------------------------------------
  assign bOp0 = bypHit0 ? bypData : bus.rf_rd0_data;
  assign bOp1 = bypHit1 ? bypData : bus.rf_rd1_data;

  assign capOp0 = (bus.wb_en && (bus.wb_index == bRs0)) ? bus.wb_data : bOp0;
  assign capOp1 = (bus.wb_en && (bus.wb_index == bRs1)) ? bus.wb_data : bOp1;

  // --------------------------------------------------------------------------
  // B stage register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bValid <= 1'b0;
      bRs0   <= 4'd0;
      bRs1   <= 4'd0;
      bTag   <= '0;
    end else if (reqFire) begin
      bValid <= 1'b1;
      bRs0   <= bus.req_rs0;
      bRs1   <= bus.req_rs1;
      bTag   <= bus.req_tag;
    end else if (reqReady) begin
      // B either was empty or has just moved into O.
      bValid <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Bypass register, updated every edge against the index actually driven
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bypHit0 <= 1'b0;
      bypHit1 <= 1'b0;
      bypData <= 32'd0;
    end else begin
      bypHit0 <= bus.wb_en && (bus.wb_index == rdIdx0);
      bypHit1 <= bus.wb_en && (bus.wb_index == rdIdx1);
      bypData <= bus.wb_data;
    end
  end

  // --------------------------------------------------------------------------
  // O stage register
  // --------------------------------------------------------------------------
`ifdef OPFETCH_HOLD_REFRESH_EN
  logic [3:0] outRs0;
  logic [3:0] outRs1;
  logic       holdWr;

  assign holdWr = outValid && !bus.out_ready && bus.wb_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outValid <= 1'b0;
      outOp0   <= 32'd0;
      outOp1   <= 32'd0;
      outTag   <= '0;
      outRs0   <= 4'd0;
      outRs1   <= 4'd0;
    end else if (oCapture) begin
      outValid <= 1'b1;
      outOp0   <= capOp0;
      outOp1   <= capOp1;
      outTag   <= bTag;
      outRs0   <= bRs0;
      outRs1   <= bRs1;
    end else begin
      if (!bValid && bus.out_ready) begin
        outValid <= 1'b0;
      end
      // Keep a stalled operand current with writes to its source register.
      if (holdWr && (bus.wb_index == outRs0)) begin
        outOp0 <= bus.wb_data;
      end
      if (holdWr && (bus.wb_index == outRs1)) begin
        outOp1 <= bus.wb_data;
      end
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      outValid <= 1'b0;
      outOp0   <= 32'd0;
      outOp1   <= 32'd0;
      outTag   <= '0;
    end else if (oCapture) begin
      outValid <= 1'b1;
      outOp0   <= capOp0;
      outOp1   <= capOp1;
      outTag   <= bTag;
    end else if (!bValid && bus.out_ready) begin
      outValid <= 1'b0;
    end
  end
`endif

  assign bus.out_valid = outValid;
  assign bus.out_op0   = outOp0;
  assign bus.out_op1   = outOp1;
  assign bus.out_tag   = outTag;

endmodule

// File: tb/tb_rf_operand_fetch.sv
module tb_rf_operand_fetch;

  typedef struct {
    logic [31:0] op0;
    logic [31:0] op1;
    logic [3:0]  tag;
  } exp_t;

  logic clk;
  logic reset_n;

  int checks;
  int errors;
  int popCount;

  exp_t expQ[$];
  exp_t monExp;

  logic [31:0] rfMem [16];
  logic [31:0] heldOp0;

  rf_operand_fetch_if #(.TAG_W(4)) bus ();

  rf_operand_fetch #(.TAG_W(4)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file model: synchronous reads that return the pre-write value.
  always @(posedge clk) begin
    bus.rf_rd0_data <= rfMem[bus.rf_rd0_index];
    bus.rf_rd1_data <= rfMem[bus.rf_rd1_index];
    if (bus.rf_wr_en) rfMem[bus.rf_wr_index] <= bus.rf_wr_data;
  end

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pushExp(input logic [31:0] op0, input logic [31:0] op1, input logic [3:0] tag);
    exp_t e;
    e.op0 = op0;
    e.op1 = op1;
    e.tag = tag;
    expQ.push_back(e);
  endtask

  // Output monitor: every accepted output must match the oldest expectation.
  always @(negedge clk) begin
    if (reset_n && bus.out_valid && bus.out_ready) begin
      checks++;
      assert (expQ.size() != 0)
      else begin
        errors++;
        $error("FAIL unexpected_output: observed tag %h expected no output", bus.out_tag);
      end
      if (expQ.size() != 0) begin
        monExp = expQ.pop_front();
        popCount++;
        check("out_op0", bus.out_op0, monExp.op0);
        check("out_op1", bus.out_op1, monExp.op1);
        check("out_tag", {28'd0, bus.out_tag}, {28'd0, monExp.tag});
      end
    end
  end

  initial begin
    checks   = 0;
    errors   = 0;
    popCount = 0;
    reset_n  = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_rs0   = 4'd0;
    bus.req_rs1   = 4'd0;
    bus.req_tag   = 4'd0;
    bus.wb_en     = 1'b0;
    bus.wb_index  = 4'd0;
    bus.wb_data   = 32'd0;
    bus.out_ready = 1'b0;
    #2;

    // Reset state, with the RF preloaded through the pass-through write port.
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_out_op0", bus.out_op0, 32'd0);
    check("rst_out_tag", {28'd0, bus.out_tag}, 32'd0);
    check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    check("rst_rd0_index", {28'd0, bus.rf_rd0_index}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      bus.wb_en    = 1'b1;
      bus.wb_index = 4'(i);
      bus.wb_data  = (i == 3) ? 32'h11 : (i == 5) ? 32'h22 : 32'h1000 + 32'(i);
      #1;
      check("wr_passthru", bus.rf_wr_data, (i == 3) ? 32'h11 : (i == 5) ? 32'h22 : 32'h1000 + 32'(i));
      step();
    end
    bus.wb_en     = 1'b0;
    bus.req_valid = 1'b1;
    bus.req_rs0   = 4'd9;
    #1;
    check("rst_rd0_index_req", {28'd0, bus.rf_rd0_index}, 32'd9);
    check("rst_out_valid_late", {31'd0, bus.out_valid}, 32'd0);
    bus.req_valid = 1'b0;
    step();
    reset_n = 1'b1;
    bus.out_ready = 1'b1;

    // Basic fetch: r3/r5, two-edge latency.
    bus.req_valid = 1'b1; bus.req_rs0 = 4'd3; bus.req_rs1 = 4'd5; bus.req_tag = 4'hA;
    pushExp(32'h11, 32'h22, 4'hA);
    step();
    check("lat_e0_out_valid", {31'd0, bus.out_valid}, 32'd0);
    bus.req_valid = 1'b0;
    step();
    check("lat_e1_out_valid", {31'd0, bus.out_valid}, 32'd1);
    step();

    // Same-edge write with rs0 == rs1: bypass register path.
    bus.req_valid = 1'b1; bus.req_rs0 = 4'd7; bus.req_rs1 = 4'd7; bus.req_tag = 4'h1;
    bus.wb_en = 1'b1; bus.wb_index = 4'd7; bus.wb_data = 32'hDEAD;
    pushExp(32'hDEAD, 32'hDEAD, 4'h1);
    step();
    bus.req_valid = 1'b0; bus.wb_en = 1'b0;
    step();
    step();

    // Write on the capture edge beats the RF value.
    bus.req_valid = 1'b1; bus.req_rs0 = 4'd2; bus.req_rs1 = 4'd4; bus.req_tag = 4'h2;
    pushExp(32'hBEEF, 32'h1004, 4'h2);
    step();
    bus.req_valid = 1'b0;
    bus.wb_en = 1'b1; bus.wb_index = 4'd2; bus.wb_data = 32'hBEEF;
    step();
    bus.wb_en = 1'b0;

    // Four back-to-back requests.
    for (int i = 0; i < 4; i++) begin
      bus.req_valid = 1'b1;
      bus.req_rs0   = 4'(8 + i);
      bus.req_rs1   = 4'(12 + i);
      bus.req_tag   = 4'(4 + i);
      pushExp(32'h1008 + 32'(i), 32'h100C + 32'(i), 4'(4 + i));
      #1;
      check("b2b_req_ready", {31'd0, bus.req_ready}, 32'd1);
      step();
      if (i >= 1) begin
        check("b2b_out_valid", {31'd0, bus.out_valid}, 32'd1);
        check("b2b_out_tag", {28'd0, bus.out_tag}, 32'(4 + i - 1));
      end
    end
    bus.req_valid = 1'b0;
    step();
    check("b2b_last_tag", {28'd0, bus.out_tag}, 32'd7);
    step();

    // Stall with two requests queued.
`ifdef OPFETCH_HOLD_REFRESH_EN
    heldOp0 = 32'h55;
`else
    heldOp0 = 32'h1001;
`endif
    bus.out_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_rs0 = 4'd1; bus.req_rs1 = 4'd6; bus.req_tag = 4'h9;
    pushExp(heldOp0, 32'h1006, 4'h9);
    step();
    bus.req_rs0 = 4'd10; bus.req_rs1 = 4'd11; bus.req_tag = 4'hA;
    pushExp(32'h77, 32'h100B, 4'hA);
    #1;
    check("stall_req_ready_b_only", {31'd0, bus.req_ready}, 32'd1);
    step();
    bus.req_valid = 1'b0;
    check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
    check("stall_capture_op0", bus.out_op0, 32'h1001);
    bus.wb_en = 1'b1; bus.wb_index = 4'd1; bus.wb_data = 32'h55;
    step();
    check("stall_held_op0", bus.out_op0, heldOp0);
    bus.wb_index = 4'd10; bus.wb_data = 32'h77;
    step();
    bus.wb_en = 1'b0;
    step();
    check("stall_out_tag", {28'd0, bus.out_tag}, 32'h9);
    check("stall_out_op1", bus.out_op1, 32'h1006);
    check("stall_req_ready_end", {31'd0, bus.req_ready}, 32'd0);
    bus.out_ready = 1'b1;
    step();
    step();
    step();

    // Reset while both stages are full.
    bus.out_ready = 1'b0;
    bus.req_valid = 1'b1; bus.req_rs0 = 4'd13; bus.req_rs1 = 4'd14; bus.req_tag = 4'h3;
    step();
    bus.req_rs0 = 4'd14; bus.req_rs1 = 4'd15; bus.req_tag = 4'h4;
    step();
    bus.req_valid = 1'b0;
    check("pre_rst_out_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_out_op0", bus.out_op0, 32'd0);
    check("mid_rst_out_op1", bus.out_op1, 32'd0);
    check("mid_rst_out_tag", {28'd0, bus.out_tag}, 32'd0);
    check("mid_rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
    step();
    reset_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    end

    check("all_outputs_seen", 32'(popCount), 32'd9);
    check("queue_empty", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
